// File: rtl/src1_pkg.sv
// src1_pkg: shared width defaults and count direction encoding for the src1 counter.
package src1_pkg;
   localparam int NUM_CNT_BITS_DEF  = 8;
   localparam int PRESCALE_BITS_DEF = 4;
   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
endpackage

// File: rtl/src1_prescaler.sv
// src1_prescaler: enable divider, emits tick once every prescale+1 enabled cycles.
//   clk, rst     : clock, synchronous active-high reset
//   restart      : synchronous return of the divider to 0 (clear or load at top)
//   count_enable : advances the divider while high
//   prescale     : divide ratio minus one
//   tick         : combinational, high on the enabled cycle that reaches prescale
module src1_prescaler
   import src1_pkg::*;
#(
   parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     restart,
   input  logic                     count_enable,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic                     tick
);
   logic [PRESCALE_BITS-1:0] pre_cnt;
   assign tick = count_enable && (pre_cnt == prescale);
   // A prescale lowered below pre_cnt lets the divider run to all-ones and wrap.
   always_ff @(posedge clk)
      if (rst || restart || tick) pre_cnt <= '0;
      else if (count_enable) pre_cnt <= pre_cnt + 1'b1;
endmodule

// File: rtl/src1_counter.sv
// src1_counter: prescaled up/down counter with rollover flag and one-cycle wrap pulse.
//   clk, rst      : clock, synchronous active-high reset
//   clear, load   : synchronous clear / load of load_val (rst > clear > load > tick)
//   count_enable  : advances the prescaler
//   up_down       : 1 counts up to rollover_val, 0 counts down and reloads rollover_val
//   prescale      : counter steps once every prescale+1 enabled cycles
//   count_out     : registered count
//   rollover_flag : combinational terminal-value indicator
//   wrap_pulse    : registered, high for the cycle after a wrap
module src1_counter
   import src1_pkg::*;
#(
   parameter int NUM_CNT_BITS  = NUM_CNT_BITS_DEF,
   parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     load,
   input  logic [NUM_CNT_BITS-1:0]  load_val,
   input  logic                     count_enable,
   input  logic                     up_down,
   input  logic [NUM_CNT_BITS-1:0]  rollover_val,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic [NUM_CNT_BITS-1:0]  count_out,
   output logic                     rollover_flag,
   output logic                     wrap_pulse
);
   logic                    tick;
   dir_t                    dir;
   logic                    at_top;
   logic                    at_zero;
   logic [NUM_CNT_BITS-1:0] next_cnt;
   logic                    next_wrap;
   src1_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
      .clk          (clk),
      .rst          (rst),
      .restart      (clear | load),
      .count_enable (count_enable),
      .prescale     (prescale),
      .tick         (tick)
   );
   assign dir           = dir_t'(up_down);
   assign at_top        = count_out == rollover_val;
   assign at_zero       = count_out == '0;
   assign rollover_flag = (dir == DIR_UP) ? at_top : at_zero;
   // Counting up past all-ones (count above rollover_val) is also a wrap.
   always_comb begin
      next_cnt  = count_out;
      next_wrap = 1'b0;
      if (tick) begin
         next_cnt  = (dir == DIR_UP) ? (at_top ? '0 : count_out + 1'b1)
                                     : (at_zero ? rollover_val : count_out - 1'b1);
         next_wrap = (dir == DIR_UP) ? (at_top || (&count_out)) : at_zero;
      end
   end
   always_ff @(posedge clk)
      if (rst || clear) begin
         count_out  <= '0;
         wrap_pulse <= 1'b0;
      end else if (load) begin
         count_out  <= load_val;
         wrap_pulse <= 1'b0;
      end else begin
         count_out  <= next_cnt;
         wrap_pulse <= next_wrap;
      end
endmodule

// File: tb/tb_src1_counter.sv
// tb_src1_counter: randomized and directed checks of src1_counter against an arithmetic model.
module tb_src1_counter;
   localparam int W = 8;
   localparam int P = 4;
   logic         tb_clk = 1'b0;
   logic         rst = 1'b0, clear = 1'b0, load = 1'b0, count_enable = 1'b0, up_down = 1'b1;
   logic [W-1:0] load_val = '0, rollover_val = '0;
   logic [P-1:0] prescale = '0;
   logic [W-1:0] count_out;
   logic         rollover_flag, wrap_pulse;
   int           compared = 0, mismatched = 0;
   int           m_cnt = 0, m_pre = 0;
   bit           m_wrap = 0;

   always #5 tb_clk = ~tb_clk;

   src1_counter #(.NUM_CNT_BITS(W), .PRESCALE_BITS(P)) dut (
      .clk           (tb_clk),
      .rst           (rst),
      .clear         (clear),
      .load          (load),
      .load_val      (load_val),
      .count_enable  (count_enable),
      .up_down       (up_down),
      .rollover_val  (rollover_val),
      .prescale      (prescale),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .wrap_pulse    (wrap_pulse)
   );

   function automatic bit exp_flag();
      return up_down ? (m_cnt == int'(rollover_val)) : (m_cnt == 0);
   endfunction

   // Advance the model by one edge from the current inputs, then wait past that edge.
   task automatic cyc();
      int top = (1 << W) - 1;
      if (rst || clear) begin
         m_cnt = 0; m_pre = 0; m_wrap = 0;
      end else if (load) begin
         m_cnt = int'(load_val); m_pre = 0; m_wrap = 0;
      end else if (count_enable && m_pre == int'(prescale)) begin
         m_pre = 0;
         if (up_down) begin
            m_wrap = (m_cnt == int'(rollover_val)) || (m_cnt == top);
            m_cnt  = (m_cnt == int'(rollover_val)) ? 0 : (m_cnt + 1) % (top + 1);
         end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt == 0) ? int'(rollover_val) : m_cnt - 1;
         end
      end else begin
         m_wrap = 0;
         if (count_enable) m_pre = (m_pre + 1) % (1 << P);
      end
      @(posedge tb_clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'($urandom); load = 1'($urandom); load_val = W'($urandom);
      count_enable = 1'($urandom); up_down = 1'($urandom); rollover_val = W'($urandom);
      prescale = P'($urandom);
      cyc(); cyc();
      compared++;
      if ({count_out, wrap_pulse, rollover_flag} !== {W'(0), 1'b0, up_down ? (rollover_val == '0) : 1'b1}) begin
         mismatched++;
         $display("FAIL reset: got cnt=%0d wrap=%0b flag=%0b, exp cnt=0 wrap=0 flag=%0b",
                  count_out, wrap_pulse, rollover_flag, up_down ? (rollover_val == '0) : 1'b1);
      end
      rst = 1'b0; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
   endtask

   task automatic test_up_count();
      int seq[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
      rst = 1'b1; cyc(); rst = 1'b0;
      rollover_val = 8'd5; prescale = '0; count_enable = 1'b1; up_down = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         compared++;
         if ({count_out, wrap_pulse, rollover_flag} !== {W'(seq[i]), i == 5, seq[i] == 5} ||
             {count_out, wrap_pulse} !== {W'(m_cnt), m_wrap}) begin
            mismatched++;
            $display("FAIL up_count step %0d: got cnt=%0d wrap=%0b flag=%0b, exp cnt=%0d wrap=%0b flag=%0b",
                     i, count_out, wrap_pulse, rollover_flag, seq[i], i == 5, seq[i] == 5);
         end
      end
   endtask

   task automatic test_prescale();
      rst = 1'b1; cyc(); rst = 1'b0;
      rollover_val = 8'd3; prescale = 4'd2; count_enable = 1'b1; up_down = 1'b1;
      for (int i = 0; i < 20; i++) begin
         count_enable = !(i >= 7 && i < 11);
         cyc();
         compared++;
         if ({count_out, wrap_pulse, rollover_flag} !== {W'(m_cnt), m_wrap, exp_flag()}) begin
            mismatched++;
            $display("FAIL prescale step %0d: got cnt=%0d wrap=%0b flag=%0b, exp cnt=%0d wrap=%0b flag=%0b",
                     i, count_out, wrap_pulse, rollover_flag, m_cnt, m_wrap, exp_flag());
         end
      end
   endtask

   task automatic test_down();
      load = 1'b1; load_val = 8'd2; rollover_val = 8'd4; up_down = 1'b0;
      prescale = '0; count_enable = 1'b1;
      cyc();
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         compared++;
         if ({count_out, wrap_pulse, rollover_flag} !== {W'(m_cnt), m_wrap, exp_flag()}) begin
            mismatched++;
            $display("FAIL down step %0d: got cnt=%0d wrap=%0b flag=%0b, exp cnt=%0d wrap=%0b flag=%0b",
                     i, count_out, wrap_pulse, rollover_flag, m_cnt, m_wrap, exp_flag());
         end
      end
   endtask

   task automatic test_priority();
      count_enable = 1'b0; clear = 1'b1; load = 1'b1; load_val = 8'd9;
      cyc();
      compared++;
      if (count_out !== W'(0)) begin
         mismatched++;
         $display("FAIL priority_clear: got cnt=%0d, exp cnt=0", count_out);
      end
      clear = 1'b0;
      cyc();
      compared++;
      if (count_out !== W'(9)) begin
         mismatched++;
         $display("FAIL priority_load: got cnt=%0d, exp cnt=9", count_out);
      end
      load = 1'b0; rollover_val = 8'd5; up_down = 1'b1; prescale = '0; count_enable = 1'b1;
      for (int i = 0; i < 248; i++) begin
         cyc();
         compared++;
         if ({count_out, wrap_pulse, rollover_flag} !== {W'(m_cnt), m_wrap, exp_flag()}) begin
            mismatched++;
            $display("FAIL above_top step %0d: got cnt=%0d wrap=%0b flag=%0b, exp cnt=%0d wrap=%0b flag=%0b",
                     i, count_out, wrap_pulse, rollover_flag, m_cnt, m_wrap, exp_flag());
         end
         if (i == 246) begin
            compared++;
            if ({count_out, wrap_pulse} !== {W'(0), 1'b1}) begin
               mismatched++;
               $display("FAIL overflow_wrap: got cnt=%0d wrap=%0b, exp cnt=0 wrap=1", count_out, wrap_pulse);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      rst = 1'b1; cyc(); rst = 1'b0;
      rollover_val = 8'd200; prescale = 4'd3; up_down = 1'b1; count_enable = 1'b1;
      while (count_out !== W'(3) && guard < 40) begin cyc(); guard++; end
      compared++;
      if (guard >= 40) begin
         mismatched++;
         $display("FAIL reset_mid_reach: got cnt=%0d after %0d cycles, exp cnt=3", count_out, guard);
      end
      cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      compared++;
      if (count_out !== W'(0)) begin
         mismatched++;
         $display("FAIL reset_mid: got cnt=%0d, exp cnt=0", count_out);
      end
      for (int i = 1; i <= 5; i++) begin
         cyc();
         compared++;
         if (count_out !== W'(i >= 4) || count_out !== W'(m_cnt)) begin
            mismatched++;
            $display("FAIL reset_mid_first_step %0d: got cnt=%0d, exp cnt=%0d", i, count_out, i >= 4);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(63) == 0);
         clear        = ($urandom_range(31) == 0);
         load         = ($urandom_range(15) == 0);
         load_val     = W'($urandom);
         count_enable = ($urandom_range(3) != 0);
         if ($urandom_range(15) == 0) up_down = 1'($urandom);
         if ($urandom_range(31) == 0) rollover_val = $urandom_range(1) ? W'($urandom_range(6)) : W'($urandom);
         if ($urandom_range(31) == 0) prescale = P'($urandom_range(3));
         cyc();
         compared++;
         if ({count_out, wrap_pulse, rollover_flag} !== {W'(m_cnt), m_wrap, exp_flag()}) begin
            mismatched++;
            $display("FAIL random cycle %0d: got cnt=%0d wrap=%0b flag=%0b, exp cnt=%0d wrap=%0b flag=%0b",
                     i, count_out, wrap_pulse, rollover_flag, m_cnt, m_wrap, exp_flag());
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_prescale();
      test_down();
      test_priority();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/src1_counter.md
Name: src1_counter

Overview:
- Programmable up/down counter with a built-in enable prescaler, rollover detection and synchronous load/clear.
- Used as a general timing/event counter block (the "src1" slot of the design).
- Single clock domain; all state updates occur on the rising edge of clk.

Parameters:
- NUM_CNT_BITS, 8, width of count_out, load_val and rollover_val.
- PRESCALE_BITS, 4, width of prescale and of the internal prescale counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of counter and prescaler.
- load  in  1  synchronous load of load_val into the counter.
- load_val  in  NUM_CNT_BITS  value loaded when load=1.
- count_enable  in  1  advances the prescaler while high.
- up_down  in  1  count direction: 1 = up, 0 = down.
- rollover_val  in  NUM_CNT_BITS  terminal value (top in up mode, reload value in down mode).
- prescale  in  PRESCALE_BITS  the counter steps once every prescale+1 enabled cycles.
- count_out  out  NUM_CNT_BITS  current count, registered.
- rollover_flag  out  1  combinational terminal indicator.
- wrap_pulse  out  1  registered one-cycle wrap indicator.

Behaviour:
- Reset (rst=1 at a rising edge): count_out=0, prescale counter=0, wrap_pulse=0.
  - rst has priority over all other inputs.
- Priority at each edge: rst > clear > load > tick.
- clear: count_out=0, prescale counter=0, wrap_pulse=0.
- load: count_out=load_val, prescale counter=0, wrap_pulse=0.
- Prescaler:
  - pre_cnt increments on each edge with count_enable=1.
  - tick = count_enable && (pre_cnt == prescale), combinational.
  - On tick, pre_cnt returns to 0.
  - With count_enable=0, pre_cnt holds.
  - prescale=0 gives a tick on every enabled cycle.
  - If prescale is lowered below pre_cnt, pre_cnt counts up to all-ones, wraps to 0, then matches normally.
- Counter on tick, up mode:
  - If count_out == rollover_val, next count is 0 and wrap_pulse is set for the next cycle.
  - Otherwise next count is count_out+1, modulo 2^NUM_CNT_BITS.
  - An all-ones to 0 overflow also sets wrap_pulse.
- Counter on tick, down mode:
  - If count_out == 0, next count is rollover_val and wrap_pulse is set.
  - Otherwise next count is count_out-1.
- No tick: count_out holds and wrap_pulse is 0.
  - wrap_pulse is high for exactly one cycle after each wrap.
- rollover_flag = (up_down ? count_out == rollover_val : count_out == 0).
- Latency:
  - count_out changes on the same edge at which tick is high, i.e. 1 cycle after the enabling inputs are sampled.
- Boundary conditions:
  - rollover_val=0 in up mode: count stays 0 and wrap_pulse fires on every tick.
  - count_out > rollover_val (after a load or a changed rollover_val) in up mode: counts up to all-ones, then wraps to 0 with wrap_pulse.
  - count_out > rollover_val in down mode: decrements normally.
  - up_down changed mid-count: takes effect at the next tick; no reset of state.
  - rst or clear during counting: immediate return to 0 at that edge; pending prescale progress is lost.

Decomposition:
- Package src1_pkg: default width constants NUM_CNT_BITS_DEF=8 and PRESCALE_BITS_DEF=4, plus a direction enum (DIR_DOWN=0, DIR_UP=1).
- Sub-module src1_prescaler:
  - Inputs: clk, rst, clear|load, count_enable, prescale.
  - Output: tick.
  - The top level holds the count register, wrap logic and flags.

Test Plan:
- Power-on reset: rst=1 for 2 cycles with random inputs -> count_out=0, wrap_pulse=0; rollover_flag=1 if up_down=0.
- Continuous up count, rollover_val=5, prescale=0, enable=1 -> count_out 0,1,2,3,4,5,0,1.
  - rollover_flag high only at 5.
  - wrap_pulse high for one cycle when the count is 0 after 5.
- Prescale=2, rollover_val=3, up -> count_out steps every 3 cycles: 0,0,0,1,1,1,2...
  - Dropping enable for 4 cycles freezes both count_out and the prescaler.
- Down mode, rollover_val=4, starting from 2 -> count_out 2,1,0,4,3 with wrap_pulse one cycle after the reload to 4.
- Priority: clear=1, load=1, load_val=9 on the same edge -> count_out=0.
  - load only -> count_out=9.
  - With rollover_val=5, up -> continues 10...255 then 0 with wrap_pulse.
- Reset mid-count at count_out=3, prescale=3 -> count_out=0 next edge.
  - Then the first increment occurs 4 enabled cycles after rst is released.
